peripheral_tap_scheduler: RTL

- Sequences and shares one TAP result stream among NUM_REQ independent bench checkers.
- Accepts a test-count configuration and emits the plan record ("1..N").
- Round-robin arbitrates checker pass/fail submissions and numbers them 1..N.
- Presents one record per cycle on a valid/ready stream to the TAP file writer; keeps pass/fail/overflow status.

---
 rtl/peripheral_tap_scheduler_if.sv | 41 ++++
 rtl/peripheral_tap_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/peripheral_tap_scheduler_if.sv
// Bundle of the configuration, checker-request and TAP-record streams.
// slave: the scheduler side. master: the environment driving it.
interface peripheral_tap_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic                         cfg_valid;
  logic [CNT_WIDTH-1:0]         cfg_numtests;
  logic                         cfg_ready;
  logic                         cfg_err;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ok;
  logic [NUM_REQ*ID_WIDTH-1:0]  req_id;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_plan;
  logic [CNT_WIDTH-1:0]         out_tc;
  logic                         out_ok;
  logic [ID_WIDTH-1:0]          out_id;
  logic [SRC_W-1:0]             out_src;
  logic [CNT_WIDTH-1:0]         pass_count;
  logic [CNT_WIDTH-1:0]         fail_count;
  logic                         done;
  logic                         err_overflow;

  modport slave (
    input  cfg_valid, cfg_numtests, req_valid, req_ok, req_id, out_ready,
    output cfg_ready, cfg_err, req_ready, out_valid, out_plan, out_tc,
           out_ok, out_id, out_src, pass_count, fail_count, done, err_overflow
  );

  modport master (
    output cfg_valid, cfg_numtests, req_valid, req_ok, req_id, out_ready,
    input  cfg_ready, cfg_err, req_ready, out_valid, out_plan, out_tc,
           out_ok, out_id, out_src, pass_count, fail_count, done, err_overflow
  );
endinterface

// File: rtl/peripheral_tap_scheduler.sv
// TAP result scheduler: emits the plan record "1..N", then round-robin
// grants checker submissions and numbers them 1..N on a valid/ready stream.
// Submissions arriving after N records are drained and flagged as overflow.
module peripheral_tap_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  peripheral_tap_scheduler_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] n_r;
  logic [CNT_WIDTH-1:0] cur_tc_r;
  logic [SRC_W-1:0]     ptr_r;
  logic                 cfg_ready_r;
  logic                 cfg_err_r;
  logic                 out_valid_r;
  logic                 out_plan_r;
  logic [CNT_WIDTH-1:0] out_tc_r;
  logic                 out_ok_r;
  logic [ID_WIDTH-1:0]  out_id_r;
  logic [SRC_W-1:0]     out_src_r;
  logic [CNT_WIDTH-1:0] pass_r;
  logic [CNT_WIDTH-1:0] fail_r;
  logic                 done_r;
  logic                 err_ovf_r;

  logic                 win_found_s;
  logic [SRC_W-1:0]     win_idx_s;
  logic                 win_ok_s;
  logic [ID_WIDTH-1:0]  win_id_s;
  logic                 grant_s;
  logic [NUM_REQ-1:0]   req_ready_s;

  // Round-robin search: first pending checker after the pointer, wrapping.
  always_comb begin
    logic [SRC_W:0] sum_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_v       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_v = {1'b0, ptr_r} + (SRC_W+1)'(k);
      if (sum_v >= (SRC_W+1)'(NUM_REQ)) begin
        sum_v = sum_v - (SRC_W+1)'(NUM_REQ);
      end else begin
        sum_v = sum_v;
      end
      if (!win_found_s && bus.req_valid[sum_v[SRC_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = sum_v[SRC_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pick the winner's result bit and description id.
  always_comb begin
    win_ok_s = 1'b0;
    win_id_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == SRC_W'(i)) begin
        win_ok_s = bus.req_ok[i];
        win_id_s = bus.req_id[i*ID_WIDTH +: ID_WIDTH];
      end else begin
        win_ok_s = win_ok_s;
      end
    end
  end

  // Grant when the output slot frees up and tests remain; in DONE, drain.
  always_comb begin
    grant_s     = 1'b0;
    req_ready_s = '0;
    case (state_r)
      ST_RUN:  grant_s = (!out_valid_r || bus.out_ready) && (cur_tc_r < n_r) && win_found_s;
      ST_DONE: grant_s = win_found_s;
      default: grant_s = 1'b0;
    endcase
    if (grant_s) begin
      req_ready_s[win_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Main sequencer: state, record register, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      n_r         <= '0;
      cur_tc_r    <= '0;
      ptr_r       <= SRC_W'(NUM_REQ-1);
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_plan_r  <= 1'b0;
      out_tc_r    <= '0;
      out_ok_r    <= 1'b0;
      out_id_r    <= '0;
      out_src_r   <= '0;
      pass_r      <= '0;
      fail_r      <= '0;
      done_r      <= 1'b0;
      err_ovf_r   <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      if (grant_s) begin
        ptr_r <= win_idx_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.cfg_valid) begin
            if (bus.cfg_numtests != '0) begin
              n_r         <= bus.cfg_numtests;
              cur_tc_r    <= '0;
              cfg_ready_r <= 1'b0;
              state_r     <= ST_HEADER;
              out_valid_r <= 1'b1;
              out_plan_r  <= 1'b1;
              out_tc_r    <= bus.cfg_numtests;
              out_ok_r    <= 1'b0;
              out_id_r    <= '0;
              out_src_r   <= '0;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (grant_s) begin
            out_valid_r <= 1'b1;
            out_plan_r  <= 1'b0;
            out_tc_r    <= cur_tc_r + CNT_WIDTH'(1);
            out_ok_r    <= win_ok_s;
            out_id_r    <= win_id_s;
            out_src_r   <= win_idx_s;
            cur_tc_r    <= cur_tc_r + CNT_WIDTH'(1);
            if (win_ok_s) begin
              pass_r <= pass_r + CNT_WIDTH'(1);
            end else begin
              fail_r <= fail_r + CNT_WIDTH'(1);
            end
          end else if ((cur_tc_r == n_r) && (!out_valid_r || bus.out_ready)) begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          if (grant_s) begin
            err_ovf_r <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready    = cfg_ready_r;
  assign bus.cfg_err      = cfg_err_r;
  assign bus.req_ready    = req_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_plan     = out_plan_r;
  assign bus.out_tc       = out_tc_r;
  assign bus.out_ok       = out_ok_r;
  assign bus.out_id       = out_id_r;
  assign bus.out_src      = out_src_r;
  assign bus.pass_count   = pass_r;
  assign bus.fail_count   = fail_r;
  assign bus.done         = done_r;
  assign bus.err_overflow = err_ovf_r;
endmodule
